// File: rtl/line_window_buf.sv
// Vertical-window line buffer.
// Each accepted raster pixel produces a WIN-pixel vertical column one cycle later.
// The column holds the current pixel plus the pixels at the same x on the WIN-1
// lines above. The history is kept as one packed word per x position in a
// dual-port RAM. The word is read when the pixel is accepted, then shifted by
// one slot and written back in the following cycle.
module line_window_buf #(
  parameter int DW     = 9,
  parameter int X_SIZE = 720,
  parameter int WIN    = 3,
  parameter int YW     = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start_in,
  input  logic                      pixel_valid_in,
  input  logic                      line_end_in,
  input  logic [DW-1:0]             pixel_in,
  input  logic                      edge_mode_in,
  output logic                      col_valid_out,
  output logic [WIN*DW-1:0]         col_out,
  output logic [$clog2(X_SIZE)-1:0] x_out,
  output logic [YW-1:0]             y_out,
  output logic                      col_full_out,
  output logic                      overflow_out
);

  localparam int XW  = $clog2(X_SIZE);
  localparam int XCW = $clog2(X_SIZE + 1);
  localparam int RW  = (WIN - 1) * DW;
  localparam logic [XCW-1:0] X_MAX  = XCW'(X_SIZE);
  localparam logic [YW-1:0]  Y_FULL = YW'(WIN - 1);

  // Line counter saturates at its maximum instead of wrapping.
  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] y);
    return (&y) ? y : y + 1'b1;
  endfunction

  // Input-side counters and sticky overflow flag
  logic [XCW-1:0] x_q, x_d, x_base;
  logic [YW-1:0]  y_q, y_d, y_base;
  logic           ovf_q, ovf_d;
  logic           accept, drop;

  // Stage 1 registers
  logic           vld_p1_q;
  logic [DW-1:0]  pix_p1_q;
  logic [XW-1:0]  x_p1_q;
  logic [YW-1:0]  y_p1_q;
  logic           edge_p1_q;

  // History RAM, its registered read port and the shifted write-back word
  logic [RW-1:0]     mem [X_SIZE];
  logic [RW-1:0]     rd_q;
  logic [WIN*DW-1:0] shift_w;
  logic [RW-1:0]     wr_data;
  logic [WIN*DW-1:0] col_w;
  logic [DW-1:0]     top_w;

  // Next-state logic: frame_start rebases the counters before this cycle's pixel is handled
  always_comb begin
    x_base = frame_start_in ? '0 : x_q;
    y_base = frame_start_in ? '0 : y_q;
    accept = pixel_valid_in && (x_base < X_MAX);
    drop   = pixel_valid_in && !(x_base < X_MAX);
    x_d    = x_base;
    y_d    = y_base;
    if (pixel_valid_in) begin
      if (line_end_in) begin
        x_d = '0;
        y_d = sat_inc_y(y_base);
      end else if (accept) begin
        x_d = x_base + 1'b1;
      end
    end
    ovf_d = frame_start_in ? 1'b0 : (ovf_q | drop);
  end

  // Control state: counters, overflow flag and stage-1 valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      vld_p1_q <= accept;
    end
  end

  // ---- stage 0 -> stage 1: capture the accepted pixel and its coordinates ----
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_p1_q  <= pixel_in;
      x_p1_q    <= x_base[XW-1:0];
      y_p1_q    <= y_base;
      edge_p1_q <= edge_mode_in;
    end
  end

  // Write the current pixel into slot 0 and move the older slots up; the oldest slot falls off.
  assign shift_w = {rd_q, pix_p1_q};
  assign wr_data = shift_w[RW-1:0];

  // RAM: read at the accepted x; write back the shifted column from stage 1
  always_ff @(posedge clk) begin
    if (accept) rd_q <= mem[x_base[XW-1:0]];
    if (vld_p1_q) mem[x_p1_q] <= wr_data;
  end

  // ---- stage 1 output: form the column and apply top-edge handling ----
  always_comb begin
    col_w = '0;
    top_w = pix_p1_q;
    // In replicate mode, use the slot that holds line 0 of the frame.
    for (int j = 0; j < WIN - 1; j++) begin
      if (y_p1_q == YW'(j + 1)) top_w = rd_q[j*DW +: DW];
    end
    col_w[DW-1:0] = pix_p1_q;
    for (int k = 1; k < WIN; k++) begin
      if (y_p1_q >= YW'(k))   col_w[k*DW +: DW] = rd_q[(k-1)*DW +: DW];
      else if (edge_p1_q)     col_w[k*DW +: DW] = top_w;
      else                    col_w[k*DW +: DW] = '0;
    end
  end

  assign col_valid_out = vld_p1_q;
  assign col_out       = vld_p1_q ? col_w : '0;
  assign x_out         = vld_p1_q ? x_p1_q : '0;
  assign y_out         = vld_p1_q ? y_p1_q : '0;
  assign col_full_out  = vld_p1_q && (y_p1_q >= Y_FULL);
  assign overflow_out  = ovf_q;

endmodule

// File: tb/tb_line_window_buf.sv
// Testbench for line_window_buf (DW=9, X_SIZE=4, WIN=3).
// The driver keeps an image model and pushes one expected column per accepted
// pixel into a scoreboard queue. A negedge monitor pops and compares each column.
// Table vectors and hand-written sequences cover the edge cases.
module tb_line_window_buf;
  localparam int DW  = 9;
  localparam int XS  = 4;
  localparam int WIN = 3;
  localparam int YW  = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              frame_start_in = 1'b0;
  logic              pixel_valid_in = 1'b0;
  logic              line_end_in = 1'b0;
  logic [DW-1:0]     pixel_in = '0;
  logic              edge_mode_in = 1'b0;
  logic              col_valid_out;
  logic [WIN*DW-1:0] col_out;
  logic [1:0]        x_out;
  logic [YW-1:0]     y_out;
  logic              col_full_out;
  logic              overflow_out;

  line_window_buf #(.DW(DW), .X_SIZE(XS), .WIN(WIN), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start_in(frame_start_in),
    .pixel_valid_in(pixel_valid_in), .line_end_in(line_end_in),
    .pixel_in(pixel_in), .edge_mode_in(edge_mode_in),
    .col_valid_out(col_valid_out), .col_out(col_out), .x_out(x_out),
    .y_out(y_out), .col_full_out(col_full_out), .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIN*DW-1:0] col;
    int                x;
    int                y;
    bit                full;
    int                cyc;
  } exp_t;

  typedef struct {
    bit          em;
    int          y;
    int          x;
    logic [8:0]  c0;
    logic [8:0]  c1;
    logic [8:0]  c2;
    bit          full;
  } vec_t;

  exp_t              sb[$];
  vec_t              tbl[6];
  logic [8:0]        img [0:15][0:3];
  logic [WIN*DW-1:0] obs_col [0:4][0:3][0:3];
  logic              obs_full [0:4][0:3][0:3];
  int                run_id = 0;
  int                n_cmp = 0;
  int                n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one pixel; when it is not meant to be dropped, record the expected column.
  task automatic drive(input int x, input int y, input bit le, input bit fs,
                       input bit em, input bit drop);
    logic [8:0] p;
    exp_t       e;
    @(posedge clk);
    #1;
    p              = 9'(16 * y + x);
    pixel_valid_in = 1'b1;
    line_end_in    = le;
    frame_start_in = fs;
    edge_mode_in   = em;
    pixel_in       = p;
    if (!drop) begin
      img[y][x] = p;
      e.col     = '0;
      e.col[8:0] = p;
      for (int k = 1; k < WIN; k++) begin
        if (y >= k)  e.col[k*9 +: 9] = img[y-k][x];
        else if (em) e.col[k*9 +: 9] = img[0][x];
      end
      e.x    = x;
      e.y    = y;
      e.full = (y >= WIN - 1);
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    pixel_valid_in = 1'b0;
    line_end_in    = 1'b0;
    frame_start_in = 1'b0;
  endtask

  task automatic stream_frame(input bit em, input int nlines, input bit gaps);
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < XS; x++) begin
        if (gaps && ($urandom_range(0, 1) == 1)) idle();
        drive(x, y, (x == XS - 1), (x == 0 && y == 0), em, 1'b0);
      end
    end
    idle();
    idle();
  endtask

  // Monitor: compare each emitted column against the scoreboard; idle outputs must be zero.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (col_valid_out) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_col: got x=%0d y=%0d col=%h, expected no column", x_out, y_out, col_out);
        end else begin
          e = sb.pop_front();
          check("col", 64'(col_out), 64'(e.col));
          check("x_out", 64'(x_out), 64'(e.x));
          check("y_out", 64'(y_out), 64'(e.y));
          check("col_full", 64'(col_full_out), 64'(e.full));
          check("latency", 64'(cyc), 64'(e.cyc + 1));
          if (y_out < 11'd4) begin
            obs_col[run_id][y_out][x_out]  = col_out;
            obs_full[run_id][y_out][x_out] = col_full_out;
          end
        end
      end else begin
        check("idle_zero", 64'({col_out, x_out, y_out, col_full_out}), 64'(0));
        if (sb.size() > 0 && sb[0].cyc + 1 < cyc) begin
          e = sb.pop_front();
          n_cmp++;
          n_fail++;
          $display("FAIL missing_col: got nothing, expected x=%0d y=%0d col=%h", e.x, e.y, e.col);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{em: 1'b0, y: 0, x: 3, c0: 9'h03, c1: 9'h00, c2: 9'h00, full: 1'b0};
    tbl[1] = '{em: 1'b0, y: 2, x: 1, c0: 9'h21, c1: 9'h11, c2: 9'h01, full: 1'b1};
    tbl[2] = '{em: 1'b0, y: 1, x: 0, c0: 9'h10, c1: 9'h00, c2: 9'h00, full: 1'b0};
    tbl[3] = '{em: 1'b1, y: 0, x: 2, c0: 9'h02, c1: 9'h02, c2: 9'h02, full: 1'b0};
    tbl[4] = '{em: 1'b1, y: 1, x: 2, c0: 9'h12, c1: 9'h02, c2: 9'h02, full: 1'b0};
    tbl[5] = '{em: 1'b1, y: 2, x: 3, c0: 9'h23, c1: 9'h13, c2: 9'h03, full: 1'b1};

    // Reset state, then idle inputs for 5 cycles
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          64'({col_valid_out, col_out, x_out, y_out, col_full_out, overflow_out}), 64'(0));
    rst_n = 1'b1;
    repeat (5) idle();
    check("idle_after_reset", 64'({col_valid_out, overflow_out}), 64'(0));

    // Gap-free frames in zero mode and replicate mode, then table spot checks
    run_id = 0;
    stream_frame(1'b0, 3, 1'b0);
    run_id = 1;
    stream_frame(1'b1, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("tbl%0d_col", i), 64'(obs_col[int'(tbl[i].em)][tbl[i].y][tbl[i].x]),
            64'({tbl[i].c2, tbl[i].c1, tbl[i].c0}));
      check($sformatf("tbl%0d_full", i), 64'(obs_full[int'(tbl[i].em)][tbl[i].y][tbl[i].x]),
            64'(tbl[i].full));
    end

    // Random input gaps must reproduce the gap-free zero-mode columns
    run_id = 2;
    stream_frame(1'b0, 3, 1'b1);
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < XS; x++)
        check($sformatf("gap_y%0d_x%0d", y, x), 64'(obs_col[2][y][x]), 64'(obs_col[0][y][x]));

    // Overflow: a fifth pixel with no line_end is dropped; the flag is sticky
    run_id = 3;
    for (int x = 0; x < XS; x++) drive(x, 0, 1'b0, (x == 0), 1'b0, 1'b0);
    drive(4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    check("drop_no_col", 64'(col_valid_out), 64'(0));
    check("ovf_set", 64'(overflow_out), 64'(1));
    drive(4, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int y = 1; y < 3; y++)
      for (int x = 0; x < XS; x++) drive(x, y, (x == XS - 1), 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    check("ovf_sticky", 64'(overflow_out), 64'(1));
    check("ovf_line2_col", 64'(obs_col[3][2][3]), 64'({9'h03, 9'h13, 9'h23}));
    @(posedge clk);
    #1;
    frame_start_in = 1'b1;
    idle();
    check("ovf_clear", 64'(overflow_out), 64'(0));

    // frame_start arriving with a pixel while the previous column is still in flight
    run_id = 4;
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < XS; x++) drive(x, y, (x == XS - 1), (x == 0 && y == 0), 1'b0, 1'b0);
    drive(0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    check("fs_prev_col", 64'(obs_col[4][2][1]), 64'({9'h01, 9'h11, 9'h21}));
    check("fs_new_valid", 64'(col_valid_out), 64'(1));
    check("fs_new_xy_full", 64'({x_out, y_out, col_full_out}), 64'(0));

    // Asynchronous reset while a column is valid
    drive(1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset",
          64'({col_valid_out, col_out, x_out, y_out, col_full_out, overflow_out}), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    idle();
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
